alu_ctrl_pipe: RTL and testbench

Registered, handshaked successor to the combinational ALU control decoder. It accepts {inst31_21, ALUOp} on a valid/ready interface, decodes an extended LEGv8 R-type set (ADD, SUB, AND, ORR, EOR, LSL, LSR, MUL), and presents control_line from a one-entry output register. MUL ops hold the output for a parametrised occupancy latency that models the multiplier. It sits between the decode stage and the execute-stage ALU/multiplier.

---
 rtl/alu_ctrl_pkg.sv | 47 ++++
 rtl/alu_ctrl_decode.sv | 59 +++++
 rtl/alu_ctrl_pipe.sv | 106 ++++++++++
 tb/tb_alu_ctrl_pipe.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_ctrl_pkg.sv
// Shared constants for the registered ALU control decoder: ALU codes,
// R-type opcodes, ALUOp classes, I-type/branch prefixes and FSM states.
package alu_ctrl_pkg;

    localparam int unsigned OPC_W_P  = 11;
    localparam int unsigned CTRL_W_P = 4;
    localparam int unsigned CNT_W    = 4;

    // ALU control codes
    localparam logic [CTRL_W_P-1:0] ALU_AND   = 4'b0000;
    localparam logic [CTRL_W_P-1:0] ALU_ORR   = 4'b0001;
    localparam logic [CTRL_W_P-1:0] ALU_ADD   = 4'b0010;
    localparam logic [CTRL_W_P-1:0] ALU_EOR   = 4'b0011;
    localparam logic [CTRL_W_P-1:0] ALU_LSL   = 4'b0100;
    localparam logic [CTRL_W_P-1:0] ALU_LSR   = 4'b0101;
    localparam logic [CTRL_W_P-1:0] ALU_SUB   = 4'b0110;
    localparam logic [CTRL_W_P-1:0] ALU_PASSB = 4'b0111;
    localparam logic [CTRL_W_P-1:0] ALU_MUL   = 4'b1000;

    // R-type opcodes (inst31_21), exact compares
    localparam logic [OPC_W_P-1:0] OPC_ADD = 11'b10001011000;
    localparam logic [OPC_W_P-1:0] OPC_SUB = 11'b11001011000;
    localparam logic [OPC_W_P-1:0] OPC_AND = 11'b10001010000;
    localparam logic [OPC_W_P-1:0] OPC_ORR = 11'b10101010000;
    localparam logic [OPC_W_P-1:0] OPC_EOR = 11'b11001010000;
    localparam logic [OPC_W_P-1:0] OPC_LSL = 11'b11010011011;
    localparam logic [OPC_W_P-1:0] OPC_LSR = 11'b11010011010;
    localparam logic [OPC_W_P-1:0] OPC_MUL = 11'b10011011000;

    // Main-control ALUOp classes
    localparam logic [1:0] ALUOP_LDST  = 2'b00;
    localparam logic [1:0] ALUOP_CBZ   = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;
    localparam logic [1:0] ALUOP_RSVD  = 2'b11;

    // Legal non-R-type prefixes that reach the decoder with ALUOp 10
    localparam logic [9:0] PFX_ADDI = 10'b1001000100;
    localparam logic [9:0] PFX_SUBI = 10'b1101000100;
    localparam logic [5:0] PFX_B    = 6'b000101;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_VALID = 2'd2
    } state_t;

endpackage

// File: rtl/alu_ctrl_decode.sv
// Pure combinational decode {inst31_21, alu_op} -> {control_line, is_mul, illegal}.
// Optional macro ALU_CTRL_ILLEGAL_OP_EN enables the illegal-op flag.
import alu_ctrl_pkg::*;

module alu_ctrl_decode (
    input  logic [OPC_W_P-1:0]  inst31_21,
    input  logic [1:0]          alu_op,
    output logic [CTRL_W_P-1:0] control_line_c,
    output logic                is_mul_c,
    output logic                illegal_c
);

    // Control code selection by ALUOp class and exact opcode
    always_comb begin
        control_line_c = ALU_ADD;
        is_mul_c       = 1'b0;
        case (alu_op)
            ALUOP_LDST: control_line_c = ALU_ADD;
            ALUOP_CBZ:  control_line_c = ALU_PASSB;
            ALUOP_RTYPE: begin
                case (inst31_21)
                    OPC_ADD: control_line_c = ALU_ADD;
                    OPC_SUB: control_line_c = ALU_SUB;
                    OPC_AND: control_line_c = ALU_AND;
                    OPC_ORR: control_line_c = ALU_ORR;
                    OPC_EOR: control_line_c = ALU_EOR;
                    OPC_LSL: control_line_c = ALU_LSL;
                    OPC_LSR: control_line_c = ALU_LSR;
                    OPC_MUL: begin
                        control_line_c = ALU_MUL;
                        is_mul_c       = 1'b1;
                    end
                    default: control_line_c = ALU_ADD;
                endcase
            end
            default: control_line_c = ALU_ADD;
        endcase
    end

`ifdef ALU_CTRL_ILLEGAL_OP_EN
    logic rtype_known;
    logic legal_prefix;

    // Opcodes that are either decoded R-types or known I-type/branch encodings
    always_comb begin
        rtype_known  = inst31_21 inside {OPC_ADD, OPC_SUB, OPC_AND, OPC_ORR,
                                         OPC_EOR, OPC_LSL, OPC_LSR, OPC_MUL};
        legal_prefix = (inst31_21[10:1] == PFX_ADDI) ||
                       (inst31_21[10:1] == PFX_SUBI) ||
                       (inst31_21[10:5] == PFX_B);
    end

    assign illegal_c = (alu_op == ALUOP_RSVD) ||
                       ((alu_op == ALUOP_RTYPE) && !rtype_known && !legal_prefix);
`else
    assign illegal_c = 1'b0;
`endif

endmodule

// File: rtl/alu_ctrl_pipe.sv
// Registered, valid/ready ALU control decoder with MUL occupancy modelling.
// Optional macro ALU_CTRL_ILLEGAL_OP_EN drives the illegal output.
import alu_ctrl_pkg::*;

module alu_ctrl_pipe #(
    parameter int unsigned OPC_W   = 11,
    parameter int unsigned CTRL_W  = 4,
    parameter int unsigned MUL_LAT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OPC_W-1:0]  inst31_21,
    input  logic [1:0]        ALUOp,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] control_line,
    output logic              is_mul,
    output logic              busy,
    output logic              illegal
);

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [CTRL_W-1:0]   control_line_q, control_line_d;
    logic                is_mul_q, is_mul_d;
    logic                illegal_q, illegal_d;

    logic [CTRL_W_P-1:0] dec_ctrl_c;
    logic                dec_mul_c;
    logic                dec_ill_c;
    logic                accept_c;

    alu_ctrl_decode u_decode (
        .inst31_21      (OPC_W_P'(inst31_21)),
        .alu_op         (ALUOp),
        .control_line_c (dec_ctrl_c),
        .is_mul_c       (dec_mul_c),
        .illegal_c      (dec_ill_c)
    );

    assign in_ready  = (state_q == ST_IDLE) || ((state_q == ST_VALID) && out_ready);
    assign accept_c  = in_valid && in_ready;
    assign out_valid = (state_q == ST_VALID);
    assign busy      = (state_q != ST_IDLE);
    assign control_line = control_line_q;
    assign is_mul       = is_mul_q;
    assign illegal      = illegal_q;

    // Next-state, occupancy counter and output register load
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        control_line_d = control_line_q;
        is_mul_d       = is_mul_q;
        illegal_d      = illegal_q;

        if (accept_c) begin
            control_line_d = CTRL_W'(dec_ctrl_c);
            is_mul_d       = dec_mul_c;
            illegal_d      = dec_ill_c;
            if (dec_mul_c && (MUL_LAT > 1)) begin
                state_d = ST_WAIT;
                cnt_d   = CNT_W'(MUL_LAT - 1);
            end else begin
                state_d = ST_VALID;
                cnt_d   = '0;
            end
        end else begin
            case (state_q)
                ST_IDLE: state_d = ST_IDLE;
                ST_WAIT: begin
                    if (cnt_q <= CNT_W'(1)) begin
                        state_d = ST_VALID;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                ST_VALID: begin
                    if (out_ready) state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // State and output registers; reset discards any in-flight op
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            cnt_q          <= '0;
            control_line_q <= '0;
            is_mul_q       <= 1'b0;
            illegal_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            control_line_q <= control_line_d;
            is_mul_q       <= is_mul_d;
            illegal_q      <= illegal_d;
        end
    end

endmodule

// File: tb/tb_alu_ctrl_pipe.sv
// Testbench for alu_ctrl_pipe: constant-table vectors, directed multi-cycle
// sequences and random traffic against a transaction-level reference model.
module tb_alu_ctrl_pipe;

    localparam int unsigned MUL_LAT = 4;
`ifdef ALU_CTRL_ILLEGAL_OP_EN
    localparam bit ILL_EN = 1'b1;
`else
    localparam bit ILL_EN = 1'b0;
`endif

    localparam logic [10:0] O_ADD  = 11'b10001011000;
    localparam logic [10:0] O_SUB  = 11'b11001011000;
    localparam logic [10:0] O_AND  = 11'b10001010000;
    localparam logic [10:0] O_ORR  = 11'b10101010000;
    localparam logic [10:0] O_EOR  = 11'b11001010000;
    localparam logic [10:0] O_LSL  = 11'b11010011011;
    localparam logic [10:0] O_LSR  = 11'b11010011010;
    localparam logic [10:0] O_MUL  = 11'b10011011000;
    localparam logic [10:0] O_ADDI = 11'b10010001000;
    localparam logic [10:0] O_ONES = 11'b11111111111;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [10:0] inst31_21 = '0;
    logic [1:0]  ALUOp = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [3:0]  control_line;
    logic        is_mul;
    logic        busy;
    logic        illegal;

    alu_ctrl_pipe #(.OPC_W(11), .CTRL_W(4), .MUL_LAT(MUL_LAT)) dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .inst31_21    (inst31_21),
        .ALUOp        (ALUOp),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .control_line (control_line),
        .is_mul       (is_mul),
        .busy         (busy),
        .illegal      (illegal)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: at most one op in flight, visible from q_ready_edge on
    int          edges = 0;
    logic        q_has = 1'b0;
    logic [3:0]  q_code;
    logic        q_mul;
    logic        q_ill;
    int          q_ready_edge;
    logic        last_in_ready;

    logic [10:0] rt_opc  [8];
    logic [3:0]  rt_code [8];

    typedef struct {
        logic [10:0] opc;
        logic [1:0]  aop;
        logic [3:0]  code;
        logic        mul;
        logic        ill;
    } vec_t;
    vec_t vt [13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (edge %0d)", name, act, exp, edges);
        end
    endtask

    // Spec-level decode: table lookup plus the illegal-op rule
    task automatic ref_dec(input logic [10:0] opc, input logic [1:0] aop,
                           output logic [3:0] code, output logic mul, output logic ill);
        bit found = 1'b0;
        code = 4'b0010;
        mul  = 1'b0;
        if (aop == 2'b01) code = 4'b0111;
        if (aop == 2'b10) begin
            for (int i = 0; i < 8; i++) begin
                if (rt_opc[i] == opc) begin
                    found = 1'b1;
                    code  = rt_code[i];
                    mul   = (i == 7);
                end
            end
        end
        ill = ILL_EN && ((aop == 2'b11) ||
              ((aop == 2'b10) && !found && (opc[10:1] != 10'b1001000100) &&
               (opc[10:1] != 10'b1101000100) && (opc[10:5] != 6'b000101)));
    endtask

    // One clock cycle: check outputs against the model, drive, advance
    task automatic step(input logic iv, input logic [10:0] opc, input logic [1:0] aop,
                        input logic ordy);
        logic exp_v, exp_ir, acc;
        logic [3:0] c;
        logic m, il;
        exp_v = q_has && (edges >= q_ready_edge);
        chk("out_valid", {31'd0, out_valid}, {31'd0, exp_v});
        chk("busy", {31'd0, busy}, {31'd0, q_has});
        if (exp_v) begin
            chk("control_line", {28'd0, control_line}, {28'd0, q_code});
            chk("is_mul", {31'd0, is_mul}, {31'd0, q_mul});
            chk("illegal", {31'd0, illegal}, {31'd0, q_ill});
        end
        in_valid  = iv;
        inst31_21 = opc;
        ALUOp     = aop;
        out_ready = ordy;
        #1;
        exp_ir = !q_has || (exp_v && ordy);
        chk("in_ready", {31'd0, in_ready}, {31'd0, exp_ir});
        last_in_ready = in_ready;
        acc = iv && exp_ir;
        if (exp_v && ordy) q_has = 1'b0;
        if (acc) begin
            ref_dec(opc, aop, c, m, il);
            q_has        = 1'b1;
            q_code       = c;
            q_mul        = m;
            q_ill        = il;
            q_ready_edge = edges + 1 + (m ? int'(MUL_LAT) - 1 : 0);
        end
        @(posedge clk);
        edges++;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 11'd0, 2'b00, 1'b1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [10:0] ropc;
        logic [1:0]  raop;

        rt_opc  = '{O_ADD, O_SUB, O_AND, O_ORR, O_EOR, O_LSL, O_LSR, O_MUL};
        rt_code = '{4'b0010, 4'b0110, 4'b0000, 4'b0001, 4'b0011, 4'b0100, 4'b0101, 4'b1000};

        vt[0]  = '{O_ADD,  2'b10, 4'b0010, 1'b0, 1'b0};
        vt[1]  = '{O_SUB,  2'b10, 4'b0110, 1'b0, 1'b0};
        vt[2]  = '{O_AND,  2'b10, 4'b0000, 1'b0, 1'b0};
        vt[3]  = '{O_ORR,  2'b10, 4'b0001, 1'b0, 1'b0};
        vt[4]  = '{O_EOR,  2'b10, 4'b0011, 1'b0, 1'b0};
        vt[5]  = '{O_LSL,  2'b10, 4'b0100, 1'b0, 1'b0};
        vt[6]  = '{O_LSR,  2'b10, 4'b0101, 1'b0, 1'b0};
        vt[7]  = '{O_MUL,  2'b10, 4'b1000, 1'b1, 1'b0};
        vt[8]  = '{O_SUB,  2'b00, 4'b0010, 1'b0, 1'b0};
        vt[9]  = '{O_MUL,  2'b01, 4'b0111, 1'b0, 1'b0};
        vt[10] = '{O_ONES, 2'b10, 4'b0010, 1'b0, ILL_EN};
        vt[11] = '{O_ADDI, 2'b10, 4'b0010, 1'b0, 1'b0};
        vt[12] = '{O_AND,  2'b11, 4'b0010, 1'b0, ILL_EN};

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_control_line", {28'd0, control_line}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        reset = 1'b0;
        #1;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);

        // Opcode sweep from constant table
        foreach (vt[i]) begin
            step(1'b1, vt[i].opc, vt[i].aop, 1'b1);
            if (vt[i].mul) idle(int'(MUL_LAT) - 1);
            chk("vec_valid", {31'd0, out_valid}, 32'd1);
            chk("vec_code", {28'd0, control_line}, {28'd0, vt[i].code});
            chk("vec_is_mul", {31'd0, is_mul}, {31'd0, vt[i].mul});
            chk("vec_illegal", {31'd0, illegal}, {31'd0, vt[i].ill});
        end
        idle(1);

        // Back-to-back SUB, AND, ORR
        step(1'b1, O_SUB, 2'b10, 1'b1);
        chk("b2b_sub", {28'd0, control_line}, 32'h6);
        step(1'b1, O_AND, 2'b10, 1'b1);
        chk("b2b_and_ready", {31'd0, last_in_ready}, 32'd1);
        chk("b2b_and", {28'd0, control_line}, 32'h0);
        step(1'b1, O_ORR, 2'b10, 1'b1);
        chk("b2b_orr_ready", {31'd0, last_in_ready}, 32'd1);
        chk("b2b_orr", {28'd0, control_line}, 32'h1);
        chk("b2b_valid", {31'd0, out_valid}, 32'd1);
        idle(1);

        // MUL occupancy with an ADD waiting behind it
        step(1'b1, O_MUL, 2'b10, 1'b1);
        for (int i = 0; i < int'(MUL_LAT) - 1; i++) begin
            step(1'b1, O_ADD, 2'b10, 1'b1);
            chk("mul_in_ready", {31'd0, last_in_ready}, 32'd0);
        end
        chk("mul_valid", {31'd0, out_valid}, 32'd1);
        chk("mul_code", {28'd0, control_line}, 32'h8);
        step(1'b1, O_ADD, 2'b10, 1'b1);
        chk("mul_add_accept", {31'd0, last_in_ready}, 32'd1);
        chk("mul_add_code", {28'd0, control_line}, 32'h2);
        idle(1);

        // Backpressure: ORR held, X opcode presented while not ready
        step(1'b1, O_ORR, 2'b10, 1'b1);
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 11'bx, 2'b10, 1'b0);
            chk("bp_in_ready", {31'd0, last_in_ready}, 32'd0);
            chk("bp_code", {28'd0, control_line}, 32'h1);
        end
        step(1'b1, O_EOR, 2'b10, 1'b1);
        chk("bp_release_accept", {31'd0, last_in_ready}, 32'd1);
        chk("bp_next_code", {28'd0, control_line}, 32'h3);
        idle(1);

        // Reset in the middle of a MUL wait
        step(1'b1, O_MUL, 2'b10, 1'b1);
        idle(1);
        reset = 1'b1;
        #1;
        chk("midwait_out_valid", {31'd0, out_valid}, 32'd0);
        chk("midwait_control_line", {28'd0, control_line}, 32'd0);
        chk("midwait_busy", {31'd0, busy}, 32'd0);
        chk("midwait_is_mul", {31'd0, is_mul}, 32'd0);
        q_has = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        step(1'b0, 11'd0, 2'b00, 1'b1);
        chk("midwait_in_ready", {31'd0, last_in_ready}, 32'd1);

        // Random traffic against the model
        for (int n = 0; n < 600; n++) begin
            case ($urandom_range(0, 11))
                0:  ropc = O_ADD;
                1:  ropc = O_SUB;
                2:  ropc = O_AND;
                3:  ropc = O_ORR;
                4:  ropc = O_EOR;
                5:  ropc = O_LSL;
                6:  ropc = O_LSR;
                7:  ropc = O_MUL;
                8:  ropc = {10'b1001000100, 1'($urandom)};
                9:  ropc = {10'b1101000100, 1'($urandom)};
                10: ropc = {6'b000101, 5'($urandom)};
                default: ropc = 11'($urandom);
            endcase
            raop = ($urandom_range(0, 3) != 0) ? 2'b10 : 2'($urandom);
            step(($urandom_range(0, 9) < 7), ropc, raop, ($urandom_range(0, 9) < 7));
        end
        idle(int'(MUL_LAT) + 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
